// File: rtl/inst_fetch_decode.sv
// Fetch stage: holds the PC, issues one instruction read at a time, decodes the
// returned RV32I word and presents it to the fetched-op queue until accepted.
module inst_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_inst,
  input  logic        foq_full,
  output logic        inst_out_valid,
  output logic [4:0]  op_out,
  output logic [4:0]  rd_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [31:0] imm_out,
  output logic        branch_out,
  output logic        ls_out,
  output logic        use_imm_out,
  output logic        jalr_out,
  output logic [31:0] addr_out,
  input  logic        predict_fail,
  input  logic [31:0] redirect_pc
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] OP_LUI   = 5'd0;
  localparam logic [4:0] OP_AUIPC = 5'd1;
  localparam logic [4:0] OP_JAL   = 5'd2;
  localparam logic [4:0] OP_JALR  = 5'd3;
  localparam logic [4:0] OP_BEQ   = 5'd4;
  localparam logic [4:0] OP_LB    = 5'd10;
  localparam logic [4:0] OP_SB    = 5'd15;
  localparam logic [4:0] OP_ILL   = 5'd31;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_OUT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        drop_reg;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign inst   = mem_resp_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  // ALU op code shared by register and immediate forms; alt selects SUB/SRA.
  function automatic logic [4:0] alu_op(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_op = alt ? 5'd19 : 5'd18;
      3'b001:  alu_op = 5'd20;
      3'b010:  alu_op = 5'd21;
      3'b011:  alu_op = 5'd22;
      3'b100:  alu_op = 5'd23;
      3'b101:  alu_op = alt ? 5'd25 : 5'd24;
      3'b110:  alu_op = 5'd26;
      default: alu_op = 5'd27;
    endcase
  endfunction

  logic [4:0]  dec_op, dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_branch, dec_ls, dec_use_imm, dec_jalr, dec_legal;

  always_comb begin
    dec_op      = OP_ILL;
    dec_rd      = 5'd0;
    dec_rs1     = 5'd0;
    dec_rs2     = 5'd0;
    dec_imm     = 32'd0;
    dec_branch  = 1'b0;
    dec_ls      = 1'b0;
    dec_use_imm = 1'b0;
    dec_jalr    = 1'b0;
    dec_legal   = 1'b1;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_op      = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
        dec_rd      = inst[11:7];
        dec_imm     = imm_u;
        dec_use_imm = 1'b1;
      end
      OPC_JAL: begin
        dec_op      = OP_JAL;
        dec_rd      = inst[11:7];
        dec_imm     = imm_j;
        dec_branch  = 1'b1;
        dec_use_imm = 1'b1;
      end
      OPC_JALR: begin
        dec_op      = OP_JALR;
        dec_rd      = inst[11:7];
        dec_rs1     = inst[19:15];
        dec_imm     = imm_i;
        dec_branch  = 1'b1;
        dec_jalr    = 1'b1;
        dec_use_imm = 1'b1;
        dec_legal   = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec_rs1    = inst[19:15];
        dec_rs2    = inst[24:20];
        dec_imm    = imm_b;
        dec_branch = 1'b1;
        case (f3)
          3'b000, 3'b001: dec_op = OP_BEQ + {4'b0, f3[0]};
          3'b100, 3'b101, 3'b110, 3'b111: dec_op = OP_BEQ + 5'd2 + {3'b0, f3[1:0]};
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_rd      = inst[11:7];
        dec_rs1     = inst[19:15];
        dec_imm     = imm_i;
        dec_ls      = 1'b1;
        dec_use_imm = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010: dec_op = OP_LB + {3'b0, f3[1:0]};
          3'b100, 3'b101:         dec_op = OP_LB + 5'd3 + {4'b0, f3[0]};
          default:                dec_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec_rs1     = inst[19:15];
        dec_rs2     = inst[24:20];
        dec_imm     = imm_s;
        dec_ls      = 1'b1;
        dec_use_imm = 1'b1;
        dec_op      = OP_SB + {3'b0, f3[1:0]};
        dec_legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      end
      OPC_OPIMM: begin
        dec_rd      = inst[11:7];
        dec_rs1     = inst[19:15];
        dec_use_imm = 1'b1;
        dec_op      = alu_op(f3, (f3 == 3'b101) && inst[30]);
        if (f3 == 3'b001) begin
          dec_imm   = imm_sh;
          dec_legal = (f7 == F7_ZERO);
        end else if (f3 == 3'b101) begin
          dec_imm   = imm_sh;
          dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        end else begin
          dec_imm   = imm_i;
        end
      end
      OPC_OP: begin
        dec_rd    = inst[11:7];
        dec_rs1   = inst[19:15];
        dec_rs2   = inst[24:20];
        dec_op    = alu_op(f3, f7 == F7_ALT);
        dec_legal = (f7 == F7_ZERO) ||
                    ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default: dec_legal = 1'b0;
    endcase
    // Anything unrecognised goes out as a bare ILLEGAL op with no operands.
    if (!dec_legal) begin
      dec_op      = OP_ILL;
      dec_rd      = 5'd0;
      dec_rs1     = 5'd0;
      dec_rs2     = 5'd0;
      dec_imm     = 32'd0;
      dec_branch  = 1'b0;
      dec_ls      = 1'b0;
      dec_use_imm = 1'b0;
      dec_jalr    = 1'b0;
    end
  end

  assign mem_req_valid = rst_in && rdy_in && (state_reg == S_FETCH);
  assign mem_req_addr  = pc_reg;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= S_FETCH;
      pc_reg         <= RESET_PC;
      drop_reg       <= 1'b0;
      inst_out_valid <= 1'b0;
      op_out         <= 5'd0;
      rd_out         <= 5'd0;
      rs1_out        <= 5'd0;
      rs2_out        <= 5'd0;
      imm_out        <= 32'd0;
      branch_out     <= 1'b0;
      ls_out         <= 1'b0;
      use_imm_out    <= 1'b0;
      jalr_out       <= 1'b0;
      addr_out       <= 32'd0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        pc_reg         <= redirect_pc;
        inst_out_valid <= 1'b0;
        // A request still in flight must be swallowed before fetching again.
        if (state_reg == S_OUT || (state_reg == S_WAIT && mem_resp_valid)) begin
          state_reg <= S_FETCH;
          drop_reg  <= 1'b0;
        end else begin
          state_reg <= S_WAIT;
          drop_reg  <= 1'b1;
        end
      end else begin
        case (state_reg)
          S_FETCH: state_reg <= S_WAIT;
          S_WAIT: begin
            if (mem_resp_valid) begin
              if (drop_reg) begin
                drop_reg  <= 1'b0;
                state_reg <= S_FETCH;
              end else begin
                op_out         <= dec_op;
                rd_out         <= dec_rd;
                rs1_out        <= dec_rs1;
                rs2_out        <= dec_rs2;
                imm_out        <= dec_imm;
                branch_out     <= dec_branch;
                ls_out         <= dec_ls;
                use_imm_out    <= dec_use_imm;
                jalr_out       <= dec_jalr;
                addr_out       <= pc_reg;
                inst_out_valid <= 1'b1;
                pc_reg         <= pc_reg + ((dec_op == OP_JAL) ? dec_imm : 32'd4);
                state_reg      <= S_OUT;
              end
            end
          end
          S_OUT: begin
            if (!foq_full) begin
              inst_out_valid <= 1'b0;
              state_reg      <= S_FETCH;
            end
          end
          default: state_reg <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Randomised bench for inst_fetch_decode: instructions are built from a chosen
// mnemonic and operands, so the expected decode is known before encoding.
module tb_inst_fetch_decode;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_inst = 32'd0;
  logic        foq_full = 1'b0;
  logic        inst_out_valid;
  logic [4:0]  op_out, rd_out, rs1_out, rs2_out;
  logic [31:0] imm_out;
  logic        branch_out, ls_out, use_imm_out, jalr_out;
  logic [31:0] addr_out;
  logic        predict_fail = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  inst_fetch_decode #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_inst(mem_resp_inst),
    .foq_full(foq_full), .inst_out_valid(inst_out_valid),
    .op_out(op_out), .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .branch_out(branch_out), .ls_out(ls_out),
    .use_imm_out(use_imm_out), .jalr_out(jalr_out), .addr_out(addr_out),
    .predict_fail(predict_fail), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        branch;
    logic        ls;
    logic        use_imm;
    logic        jalr;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int txn_cnt = 0;
  logic [31:0] model_pc;

  logic [2:0]  br_f3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0]  ld_f3 [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  ia_f3 [6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [4:0]  ia_op [6]  = '{5'd18, 5'd21, 5'd22, 5'd23, 5'd26, 5'd27};
  logic [6:0]  r_f7  [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
  logic [2:0]  r_f3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  logic [4:0]  r_op  [10] = '{5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27};
  logic [31:0] ill   [11] = '{32'hFFFFFFFF, 32'h00000073, 32'h0000000F, 32'h02208033,
                              32'h00002063, 32'h00003003, 32'h00003023, 32'h40001013,
                              32'h00001067, 32'h00000000, 32'h40002033};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_fields(input exp_t e, input logic [31:0] pc);
    check("op",      32'(op_out),      32'(e.op));
    check("rd",      32'(rd_out),      32'(e.rd));
    check("rs1",     32'(rs1_out),     32'(e.rs1));
    check("rs2",     32'(rs2_out),     32'(e.rs2));
    check("imm",     imm_out,          e.imm);
    check("branch",  32'(branch_out),  32'(e.branch));
    check("ls",      32'(ls_out),      32'(e.ls));
    check("use_imm", 32'(use_imm_out), 32'(e.use_imm));
    check("jalr",    32'(jalr_out),    32'(e.jalr));
    check("addr",    addr_out,         pc);
  endtask

  task automatic gen_inst(output logic [31:0] w, output exp_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] iv;
    int          sel;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    iv  = 32'(int'($urandom_range(0, 4095)) - 2048);
    e   = '0;
    w   = 32'd0;
    case ($urandom_range(0, 10))
      0, 1: begin
        iv = $urandom & 32'hFFFFF000;
        sel = int'($urandom_range(0, 1));
        w = {iv[31:12], rd, (sel == 0) ? 7'b0110111 : 7'b0010111};
        e.op = 5'(sel); e.rd = rd; e.imm = iv; e.use_imm = 1'b1;
      end
      2: begin
        iv = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        w = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
        e.op = 5'd2; e.rd = rd; e.imm = iv; e.branch = 1'b1; e.use_imm = 1'b1;
      end
      3: begin
        w = {iv[11:0], rs1, 3'b000, rd, 7'b1100111};
        e.op = 5'd3; e.rd = rd; e.rs1 = rs1; e.imm = iv;
        e.branch = 1'b1; e.jalr = 1'b1; e.use_imm = 1'b1;
      end
      4: begin
        sel = int'($urandom_range(0, 5));
        iv = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        w = {iv[12], iv[10:5], rs2, rs1, br_f3[sel], iv[4:1], iv[11], 7'b1100011};
        e.op = 5'(4 + sel); e.rs1 = rs1; e.rs2 = rs2; e.imm = iv; e.branch = 1'b1;
      end
      5: begin
        sel = int'($urandom_range(0, 4));
        w = {iv[11:0], rs1, ld_f3[sel], rd, 7'b0000011};
        e.op = 5'(10 + sel); e.rd = rd; e.rs1 = rs1; e.imm = iv;
        e.ls = 1'b1; e.use_imm = 1'b1;
      end
      6: begin
        sel = int'($urandom_range(0, 2));
        w = {iv[11:5], rs2, rs1, 3'(sel), iv[4:0], 7'b0100011};
        e.op = 5'(15 + sel); e.rs1 = rs1; e.rs2 = rs2; e.imm = iv;
        e.ls = 1'b1; e.use_imm = 1'b1;
      end
      7: begin
        sel = int'($urandom_range(0, 5));
        w = {iv[11:0], rs1, ia_f3[sel], rd, 7'b0010011};
        e.op = ia_op[sel]; e.rd = rd; e.rs1 = rs1; e.imm = iv; e.use_imm = 1'b1;
      end
      8: begin
        sel = int'($urandom_range(0, 2));
        w = {(sel == 2) ? 7'h20 : 7'h00, rs2, rs1, (sel == 0) ? 3'd1 : 3'd5, rd, 7'b0010011};
        e.op = (sel == 0) ? 5'd20 : ((sel == 1) ? 5'd24 : 5'd25);
        e.rd = rd; e.rs1 = rs1; e.imm = {27'b0, rs2}; e.use_imm = 1'b1;
      end
      9: begin
        sel = int'($urandom_range(0, 9));
        w = {r_f7[sel], rs2, rs1, r_f3[sel], rd, 7'b0110011};
        e.op = r_op[sel]; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
      end
      default: begin
        sel = int'($urandom_range(0, 10));
        w = ill[sel];
        e.op = 5'd31;
      end
    endcase
  endtask

  function automatic exp_t addi_exp(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    exp_t e;
    e = '0;
    e.op = 5'd18; e.rd = rd; e.rs1 = rs1; e.imm = imm; e.use_imm = 1'b1;
    return e;
  endfunction

  // Called at a negedge where the DUT should be issuing a request for model_pc.
  task automatic run_txn(input logic [31:0] w, input exp_t e, input int lat, input int stall);
    logic [31:0] pc_now;
    pc_now = model_pc;
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_addr", mem_req_addr, pc_now);
    check("ov_fetch", 32'(inst_out_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk_in);
      check("req_wait", 32'(mem_req_valid), 32'd0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_inst  = w;
    @(negedge clk_in);
    mem_resp_valid = 1'b0;
    check("ov_out", 32'(inst_out_valid), 32'd1);
    check_fields(e, pc_now);
    model_pc = (e.op == 5'd2) ? pc_now + e.imm : pc_now + 32'd4;
    foq_full = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_inst  = $urandom;
      @(negedge clk_in);
      check("ov_hold", 32'(inst_out_valid), 32'd1);
      check("op_hold", 32'(op_out), 32'(e.op));
      check("imm_hold", imm_out, e.imm);
      check("addr_hold", addr_out, pc_now);
      check("req_hold", 32'(mem_req_valid), 32'd0);
    end
    mem_resp_valid = 1'b0;
    foq_full = 1'b0;
    @(negedge clk_in);
    txn_cnt++;
    $display("txn %0d: pc=%h inst=%h op=%0d lat=%0d stall=%0d", txn_cnt, pc_now, w, e.op, lat, stall);
  endtask

  // Mispredict scenarios: 0 in WAIT, 1 with a coinciding response, 2 in FETCH, 3 in OUT.
  task automatic run_pf(input int mode, input logic [31:0] r);
    check("pf_req_valid", 32'(mem_req_valid), 32'd1);
    check("pf_req_addr", mem_req_addr, model_pc);
    case (mode)
      0: begin
        @(negedge clk_in);
        predict_fail = 1'b1; redirect_pc = r;
        @(negedge clk_in);
        predict_fail = 1'b0;
        check("pf_ov_wait", 32'(inst_out_valid), 32'd0);
        @(negedge clk_in);
        mem_resp_valid = 1'b1; mem_resp_inst = 32'h00500093;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
      end
      1: begin
        @(negedge clk_in);
        mem_resp_valid = 1'b1; mem_resp_inst = 32'h00500093;
        predict_fail = 1'b1; redirect_pc = r;
        @(negedge clk_in);
        mem_resp_valid = 1'b0; predict_fail = 1'b0;
      end
      2: begin
        predict_fail = 1'b1; redirect_pc = r;
        @(negedge clk_in);
        predict_fail = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_inst = 32'h00500093;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
      end
      default: begin
        @(negedge clk_in);
        mem_resp_valid = 1'b1; mem_resp_inst = 32'h00500093;
        @(negedge clk_in);
        mem_resp_valid = 1'b0;
        check("pf_ov_out", 32'(inst_out_valid), 32'd1);
        foq_full = 1'b1; predict_fail = 1'b1; redirect_pc = r;
        @(negedge clk_in);
        predict_fail = 1'b0; foq_full = 1'b0;
      end
    endcase
    check("pf_ov_after", 32'(inst_out_valid), 32'd0);
    model_pc = r;
    txn_cnt++;
    $display("txn %0d: predict_fail mode=%0d redirect=%h", txn_cnt, mode, r);
  endtask

  task automatic run_rdy_stall(input logic [31:0] w, input exp_t e);
    logic [31:0] pc_now;
    pc_now = model_pc;
    check("rdy_req_pre", 32'(mem_req_valid), 32'd1);
    rdy_in = 1'b0;
    #1 check("rdy_req_forced", 32'(mem_req_valid), 32'd0);
    repeat (2) begin
      @(negedge clk_in);
      check("rdy_req_fetch", 32'(mem_req_valid), 32'd0);
    end
    rdy_in = 1'b1;
    #1 check("rdy_req_resume", 32'(mem_req_valid), 32'd1);
    check("rdy_req_addr", mem_req_addr, pc_now);
    @(negedge clk_in);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("rdy_wait_req", 32'(mem_req_valid), 32'd0);
      check("rdy_wait_ov", 32'(inst_out_valid), 32'd0);
    end
    rdy_in = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_inst = w;
    @(negedge clk_in);
    mem_resp_valid = 1'b0;
    check("rdy_ov", 32'(inst_out_valid), 32'd1);
    check_fields(e, pc_now);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      check("rdy_out_ov", 32'(inst_out_valid), 32'd1);
      check("rdy_out_op", 32'(op_out), 32'(e.op));
      check("rdy_out_req", 32'(mem_req_valid), 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    model_pc = pc_now + 32'd4;
    txn_cnt++;
    $display("txn %0d: rdy_in stall pc=%h inst=%h", txn_cnt, pc_now, w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    exp_t        e;
    exp_t        ill_e;

    ill_e = '0;
    ill_e.op = 5'd31;
    model_pc = 32'h0;

    repeat (3) @(negedge clk_in);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, 32'd0);
    check("rst_ov", 32'(inst_out_valid), 32'd0);
    check("rst_op", 32'(op_out), 32'd0);
    check("rst_imm", imm_out, 32'd0);
    check("rst_addr_out", addr_out, 32'd0);
    rst_in = 1'b1;
    #1;

    // addi x1,x0,5 x4, then jal x0,8 at pc 0x10
    for (int i = 0; i < 4; i++) run_txn(32'h00500093, addi_exp(5'd1, 5'd0, 32'd5), 1, 0);
    e = '0; e.op = 5'd2; e.imm = 32'd8; e.branch = 1'b1; e.use_imm = 1'b1;
    run_txn(32'h0080006F, e, 2, 0);
    run_txn(32'h00500093, addi_exp(5'd1, 5'd0, 32'd5), 1, 5);
    run_pf(0, 32'h00000100);
    run_rdy_stall(32'hFFF08113, addi_exp(5'd2, 5'd1, 32'hFFFFFFFF));
    run_txn(32'hFFFFFFFF, ill_e, 1, 1);
    run_pf(1, 32'h00000200);
    run_pf(2, 32'h00000300);
    run_pf(3, 32'hFFFFFFFC);
    run_txn(32'h00500093, addi_exp(5'd1, 5'd0, 32'd5), 3, 0);
    check("wrap_pc", model_pc, 32'h0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        run_pf(int'($urandom_range(0, 3)), $urandom & 32'hFFFFFFFC);
      end else begin
        gen_inst(w, e);
        run_txn(w, e, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
      end
    end

    // Reset asserted while an instruction is held in OUT
    check("mid_req_valid", 32'(mem_req_valid), 32'd1);
    @(negedge clk_in);
    mem_resp_valid = 1'b1; mem_resp_inst = 32'h00500093;
    @(negedge clk_in);
    mem_resp_valid = 1'b0;
    foq_full = 1'b1;
    check("mid_ov_before", 32'(inst_out_valid), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("mid_ov_reset", 32'(inst_out_valid), 32'd0);
    check("mid_req_reset", 32'(mem_req_valid), 32'd0);
    check("mid_pc_reset", mem_req_addr, 32'h0);
    check("mid_op_reset", 32'(op_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    foq_full = 1'b0;
    #1;
    model_pc = 32'h0;
    run_txn(32'h00500093, addi_exp(5'd1, 5'd0, 32'd5), 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_decode.md
Name: inst_fetch_decode

Overview:
Fetch stage directly upstream of the fetched-op queue. Keeps the PC and issues one instruction-memory request at a time. Decodes each returned RV32I word into the queue's field format, then holds the result until the queue accepts it. JAL redirects the PC locally; B-type and JALR are predicted fall-through. A backend mispredict (predict_fail) redirects the PC and squashes in-flight work.

Parameters:
RESET_PC, 32'h0, PC loaded at reset.

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  global ready; low freezes all state
mem_req_valid  out  1  instruction read request, single-cycle pulse
mem_req_addr  out  32  request address (= pc)
mem_resp_valid  in  1  instruction word valid
mem_resp_inst  in  32  instruction word
foq_full  in  1  queue full; push happens only when low
inst_out_valid  out  1  decoded instruction presented to queue
op_out/rd_out/rs1_out/rs2_out  out  5 each  decoded op and register indices
imm_out  out  32  sign-extended immediate
branch_out/ls_out/use_imm_out/jalr_out  out  1 each  class flags
addr_out  out  32  PC of the presented instruction
predict_fail  in  1  backend mispredict
redirect_pc  in  32  correct PC, valid with predict_fail

Behaviour:
- Reset (rst_in=0, async):
  - pc=RESET_PC, state=FETCH, drop=0.
  - All outputs 0, including inst_out_valid and mem_req_valid.
- rdy_in=0: no state change. Outputs hold. mem_req_valid is forced 0.
- FSM states are FETCH, WAIT, OUT. mem_req_valid=1 only in FETCH with rdy_in=1.
- FETCH:
  - mem_req_addr=pc.
  - Next cycle goes to WAIT.
- WAIT, on mem_resp_valid:
  - Register the decoded fields and addr_out=pc.
  - Set inst_out_valid=1 and go to OUT.
  - pc := pc+imm for JAL, otherwise pc+4.
  - mem_resp_valid outside WAIT is ignored. One outstanding request max.
- OUT, with foq_full=0: the queue takes the push this cycle. Clear inst_out_valid and go to FETCH. With foq_full=1: hold all outputs.
- Latency: output is valid the cycle after mem_resp_valid. Next request is issued the cycle after acceptance.
- predict_fail (highest priority over everything except reset):
  - pc := redirect_pc. inst_out_valid := 0 next cycle.
  - From FETCH or WAIT: go to WAIT with drop=1. A request already issued this cycle still completes.
  - From OUT: go to FETCH.
  - In WAIT with drop=1, the next response is discarded: drop:=0, go to FETCH.
  - predict_fail coinciding with mem_resp_valid in WAIT: the response is discarded and the state goes to FETCH.
- Op codes:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR.
  - 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU.
  - 10 LB, 11 LH, 12 LW, 13 LBU, 14 LHU, 15 SB, 16 SH, 17 SW.
  - 18 ADD, 19 SUB, 20 SLL, 21 SLT, 22 SLTU, 23 XOR, 24 SRL, 25 SRA, 26 OR, 27 AND.
  - 31 ILLEGAL.
  - I-type ALU instructions map to the R-type code with use_imm=1. There is no I-type SUB.
- Field rules:
  - Unused rd/rs1/rs2 output 0: rd for B/S types; rs1 for LUI/AUIPC/JAL; rs2 except R/B/S types.
  - imm is sign-extended per I/S/B/U/J format. U-type imm is inst[31:12]<<12.
  - For SLLI/SRLI/SRAI, imm is shamt zero-extended. R-type imm is 0.
- Flag rules:
  - branch=1 for B-type, JAL and JALR. jalr=1 for JALR only.
  - ls=1 for loads and stores.
  - use_imm=1 for I-ALU, loads, stores, LUI, AUIPC, JAL and JALR.
- Illegal or unsupported encodings (FENCE, ECALL, bad funct):
  - op=31, all other fields 0, addr_out valid.
  - Pushed normally; next pc=pc+4.
- PC arithmetic is mod 2^32. Wrap from 32'hFFFFFFFC to 0 is legal.

Test Plan:
- Reset then release; memory returns 32'h00500093 (addi x1,x0,5) -> mem_req_addr=0; output op=18, rd=1, rs1=0, imm=5, use_imm=1; next request addr=4.
- pc=0x10, inst 32'h0080006F (jal x0,8) -> op=2, branch=1, imm=8, addr_out=0x10; next mem_req_addr=0x18.
- foq_full=1 for 5 cycles while OUT -> inst_out_valid and fields stable, no mem_req_valid; foq_full=0 -> accepted, request issued next cycle.
- predict_fail with redirect_pc=0x100 while WAIT; response arrives 2 cycles later -> response discarded, inst_out_valid stays 0, next mem_req_addr=0x100.
- rdy_in=0 across a response-pending WAIT and OUT -> no state or output change, no requests; resume -> continues as normal.
- Inst 32'hFFFFFFFF -> op=31, other fields 0, pushed, next addr=pc+4. Reset asserted mid-OUT -> inst_out_valid=0 immediately, pc=RESET_PC.
